i2c_reg_init_seq: RTL



---
 rtl/i2c_reg_init_seq.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_reg_init_seq.sv
// Table-driven I2C register-initialisation sequencer: walks {op, reg, data} entries,
// drives the byte-level controller's GO/END/ACK handshake, retries NACKs and re-runs on request.
module i2c_reg_init_seq #(
    parameter int         CLK_FREQ      = 50000000,
    parameter int         I2C_FREQ      = 20000,
    parameter logic [7:0] DEV_ADDR      = 8'h72,
    parameter int         REG_W         = 8,
    parameter int         DATA_W        = 8,
    parameter int         ADDR_W        = 6,
    parameter int         NUM_ENTRIES   = 31,
    parameter int         MAX_RETRY     = 3,
    parameter int         TRIG_DEBOUNCE = 4,
    parameter bit         AUTO_START    = 1'b1
) (
    input  logic                          iCLK,
    input  logic                          iRST,
    input  logic                          iSTART,
    input  logic                          iTRIG_N,
    output logic                          oTICK,
    output logic [ADDR_W-1:0]             oROM_ADDR,
    input  logic [REG_W+DATA_W:0]         iROM_DATA,
    output logic [8+REG_W+DATA_W-1:0]     oI2C_DATA,
    output logic                          oI2C_GO,
    input  logic                          iI2C_END,
    input  logic                          iI2C_ACK,
    output logic                          oBUSY,
    output logic                          oDONE,
    output logic                          oERROR,
    output logic [ADDR_W-1:0]             oERR_INDEX
);

    localparam int PAY_W   = REG_W + DATA_W;
    localparam int DIV_RAW = CLK_FREQ / (2 * I2C_FREQ);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int DEB_W   = (TRIG_DEBOUNCE > 1) ? $clog2(TRIG_DEBOUNCE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_GAP,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_e;

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        divCnt_q;
    logic                    tick;
    logic [ADDR_W-1:0]       index_q, index_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [PAY_W-1:0]        delay_q, delay_d;
    logic [8+PAY_W-1:0]      i2cData_q, i2cData_d;
    logic                    go_q, go_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [ADDR_W-1:0]       errIndex_q, errIndex_d;
    logic                    pending_q, pending_d;
    logic [DEB_W-1:0]        deb_q, deb_d;

    logic                    romOp;
    logic [PAY_W-1:0]        romPayload;

    assign romOp      = iROM_DATA[PAY_W];
    assign romPayload = iROM_DATA[PAY_W-1:0];

    // Free-running work-tick divider shared with the I2C controller.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            divCnt_q <= '0;
        end else if (divCnt_q == DIV_W'(DIV - 1)) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + DIV_W'(1);
        end
    end

    assign tick = (divCnt_q == DIV_W'(DIV - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            index_q    <= '0;
            retry_q    <= '0;
            delay_q    <= '0;
            i2cData_q  <= '0;
            go_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            errIndex_q <= '0;
            pending_q  <= AUTO_START;
            deb_q      <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            retry_q    <= retry_d;
            delay_q    <= delay_d;
            i2cData_q  <= i2cData_d;
            go_q       <= go_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            errIndex_q <= errIndex_d;
            pending_q  <= pending_d;
            deb_q      <= deb_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        retry_d    = retry_q;
        delay_d    = delay_q;
        i2cData_d  = i2cData_q;
        go_d       = go_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        errIndex_d = errIndex_q;
        pending_d  = pending_q;
        deb_d      = deb_q;

        if (iSTART && !busy_q) begin
            pending_d = 1'b1;
        end

        // Re-run trigger only arms in DONE/ERROR; any high tick restarts the count.
        if (busy_q || !((state_q == S_DONE) || (state_q == S_ERROR))) begin
            deb_d = '0;
        end else if (tick) begin
            if (iTRIG_N) begin
                deb_d = '0;
            end else if (deb_q == DEB_W'(TRIG_DEBOUNCE - 1)) begin
                deb_d     = '0;
                pending_d = 1'b1;
            end else begin
                deb_d = deb_q + DEB_W'(1);
            end
        end

        if (tick) begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (pending_q) begin
                        index_d   = '0;
                        retry_d   = '0;
                        done_d    = 1'b0;
                        error_d   = 1'b0;
                        busy_d    = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (!romOp) begin
                        i2cData_d = {DEV_ADDR, romPayload};
                        go_d      = 1'b1;
                        state_d   = S_WAIT;
                    end else if (romPayload == '0) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        delay_d = romPayload;
                        state_d = S_DELAY;
                    end
                end
                S_WAIT: begin
                    if (iI2C_END) begin
                        go_d = 1'b0;
                        if (!iI2C_ACK) begin
                            state_d = S_NEXT;
                        end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                            retry_d = retry_q + RETRY_W'(1);
                            state_d = S_GAP;
                        end else begin
                            errIndex_d = index_q;
                            error_d    = 1'b1;
                            busy_d     = 1'b0;
                            state_d    = S_ERROR;
                        end
                    end
                end
                S_GAP: begin
                    go_d    = 1'b1;
                    state_d = S_WAIT;
                end
                S_DELAY: begin
                    if (delay_q <= PAY_W'(1)) begin
                        delay_d = '0;
                        state_d = S_NEXT;
                    end else begin
                        delay_d = delay_q - PAY_W'(1);
                    end
                end
                S_NEXT: begin
                    retry_d = '0;
                    if (index_q == ADDR_W'(NUM_ENTRIES - 1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign oTICK      = tick;
    assign oROM_ADDR  = index_q;
    assign oI2C_DATA  = i2cData_q;
    assign oI2C_GO    = go_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oERROR     = error_q;
    assign oERR_INDEX = errIndex_q;

endmodule
